// File: rtl/credit_update_arbiter.sv
// Coalesces per-port freespace-update pulses into pending credit counts and
// returns them to the BFT as one round-robin arbitrated credit packet at a time.
module credit_update_arbiter #(
    parameter int unsigned NUM_IN_PORTS  = 4,
    parameter int unsigned PACKET_BITS   = 97,
    parameter int unsigned NUM_LEAF_BITS = 6,
    parameter int unsigned NUM_PORT_BITS = 4,
    parameter int unsigned PAYLOAD_BITS  = 64,
    parameter int unsigned CNT_BITS      = 8,
    parameter int unsigned PORT_BASE     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_IN_PORTS-1:0]  freespace_update,
    input  logic [NUM_LEAF_BITS-1:0] src_leaf,
    output logic [PACKET_BITS-1:0]   packet_out,
    output logic                     vld_out,
    input  logic                     ack_in,
    output logic                     overflow
);

    localparam int unsigned PTR_W    = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
    localparam int unsigned PAD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_IN_PORTS - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_BITS-1:0]      pending_q [NUM_IN_PORTS];
    logic [PTR_W-1:0]         rr_q, rr_d;
    logic [PACKET_BITS-1:0]   packet_q, packet_d;
    logic                     overflow_q;

    logic [PTR_W:0]           idx_c;
    logic [PTR_W-1:0]         win_c;
    logic                     any_c;
    logic                     slot_free_c;
    logic                     grant_c;
    logic [NUM_PORT_BITS-1:0] port_id_c;
    logic [PAYLOAD_BITS-1:0]  payload_c;
    logic [PACKET_BITS-1:0]   cand_pkt_c;

    // Cyclic first-nonzero search over registered counters, starting at rr_q
    always_comb begin
        win_c = '0;
        any_c = 1'b0;
        idx_c = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            idx_c = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (idx_c >= (PTR_W+1)'(NUM_IN_PORTS)) begin
                idx_c = idx_c - (PTR_W+1)'(NUM_IN_PORTS);
            end
            if (!any_c && (pending_q[idx_c[PTR_W-1:0]] != '0)) begin
                any_c = 1'b1;
                win_c = idx_c[PTR_W-1:0];
            end
        end
    end

    assign port_id_c  = NUM_PORT_BITS'(PORT_BASE + 32'(win_c));
    assign payload_c  = PAYLOAD_BITS'(pending_q[win_c]);
    assign cand_pkt_c = {1'b1, src_leaf, port_id_c, {PAD_BITS{1'b0}}, payload_c};

    assign slot_free_c = (state_q == IDLE) || ack_in;
    assign grant_c     = slot_free_c && enable && any_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            packet_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            packet_q <= packet_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        packet_d = packet_q;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d  = HOLD;
                    packet_d = cand_pkt_c;
                    rr_d     = (win_c == LAST_IDX) ? '0 : win_c + PTR_W'(1);
                end
            end
            HOLD: begin
                if (grant_c) begin
                    packet_d = cand_pkt_c;
                    rr_d     = (win_c == LAST_IDX) ? '0 : win_c + PTR_W'(1);
                end else if (ack_in) begin
                    state_d  = IDLE;
                    packet_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                packet_d = '0;
            end
        endcase
    end

    // Granted counter restarts from the same-cycle pulse so no credit is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                pending_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                if (grant_c && (win_c == PTR_W'(i))) begin
                    pending_q[i] <= CNT_BITS'(freespace_update[i]);
                end else if (freespace_update[i]) begin
                    if (pending_q[i] == CNT_MAX) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pending_q[i] <= pending_q[i] + CNT_BITS'(1);
                    end
                end
            end
        end
    end

    assign packet_out = packet_q;
    assign vld_out    = (state_q == HOLD);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_credit_update_arbiter.sv
// Directed bench for credit_update_arbiter: table of per-cycle vectors plus
// hand-written saturation and asynchronous-reset sequences.
module tb_credit_update_arbiter;

    localparam logic [5:0] LEAF = 6'h2A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  freespace_update;
    logic [5:0]  src_leaf;
    logic [96:0] packet_out;
    logic        vld_out;
    logic        ack_in;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    credit_update_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .freespace_update (freespace_update),
        .src_leaf         (src_leaf),
        .packet_out       (packet_out),
        .vld_out          (vld_out),
        .ack_in           (ack_in),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fsu;
        logic       en;
        logic       ack;
        logic       vld;
        int         port;
        int         pay;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [96:0] mk_pkt(input int port, input int pay);
        logic [3:0]  pid;
        logic [63:0] p;
        pid = 4'(2 + port);
        p   = 64'(pay);
        return {1'b1, LEAF, pid, 22'd0, p};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] fsu, input logic en, input logic ack);
        freespace_update = fsu;
        enable           = en;
        ack_in           = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] fsu, input logic en, input logic ack,
                       input logic vld, input int port, input int pay);
        vec_t v;
        v.fsu = fsu; v.en = en; v.ack = ack; v.vld = vld; v.port = port; v.pay = pay;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b1;
        freespace_update = '0;
        src_leaf         = LEAF;
        ack_in           = 1'b1;

        // Round robin from reset pointer 0
        add(4'b1111, 1, 1, 0, 0, 0);
        add(4'b0000, 1, 1, 1, 0, 1);
        add(4'b0000, 1, 1, 1, 1, 1);
        add(4'b0000, 1, 1, 1, 2, 1);
        add(4'b0000, 1, 1, 1, 3, 1);
        add(4'b0000, 1, 1, 0, 0, 0);
        // Single credit on port 1 (port id 3)
        add(4'b0010, 1, 1, 0, 0, 0);
        add(4'b0000, 1, 1, 1, 1, 1);
        add(4'b0000, 1, 1, 0, 0, 0);
        // Round robin with pointer at 2
        add(4'b1111, 1, 1, 0, 0, 0);
        add(4'b0000, 1, 1, 1, 2, 1);
        add(4'b0000, 1, 1, 1, 3, 1);
        add(4'b0000, 1, 1, 1, 0, 1);
        add(4'b0000, 1, 1, 1, 1, 1);
        add(4'b0000, 1, 1, 0, 0, 0);
        // Coalescing on port 2 while port 0 is held
        add(4'b0001, 1, 0, 0, 0, 0);
        add(4'b0100, 1, 0, 1, 0, 1);
        add(4'b0100, 1, 0, 1, 0, 1);
        add(4'b0100, 1, 0, 1, 0, 1);
        add(4'b0100, 1, 0, 1, 0, 1);
        add(4'b0100, 1, 0, 1, 0, 1);
        add(4'b0000, 1, 1, 1, 2, 5);
        add(4'b0000, 1, 1, 0, 0, 0);
        add(4'b0000, 1, 1, 0, 0, 0);
        // Pulse in the grant cycle is kept for a follow-up packet
        add(4'b0010, 0, 0, 0, 0, 0);
        add(4'b0010, 0, 0, 0, 0, 0);
        add(4'b0010, 0, 0, 0, 0, 0);
        add(4'b0010, 1, 0, 1, 1, 3);
        add(4'b0000, 1, 1, 1, 1, 1);
        add(4'b0000, 1, 1, 0, 0, 0);
        // enable=0 blocks grants but not a held packet
        add(4'b0001, 1, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 0);
        add(4'b0000, 1, 0, 1, 0, 1);
        add(4'b1000, 0, 0, 1, 0, 1);
        add(4'b0000, 0, 1, 0, 0, 0);
        add(4'b0000, 1, 1, 1, 3, 1);
        add(4'b0000, 1, 1, 0, 0, 0);

        #1;
        chk("reset_vld", 128'(vld_out), 128'(0));
        chk("reset_pkt", 128'(packet_out), 128'(0));
        chk("reset_ovf", 128'(overflow), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].fsu, tbl[i].en, tbl[i].ack);
            chk($sformatf("vec%0d_vld", i), 128'(vld_out), 128'(tbl[i].vld));
            chk($sformatf("vec%0d_pkt", i), 128'(packet_out),
                tbl[i].vld ? 128'(mk_pkt(tbl[i].port, tbl[i].pay)) : 128'(0));
            chk($sformatf("vec%0d_ovf", i), 128'(overflow), 128'(0));
        end

        // Saturation: 300 pulses on port 0 with grants disabled
        for (int i = 0; i < 300; i++) begin
            step(4'b0001, 0, 1);
            if (i == 254) chk("sat_255_no_ovf", 128'(overflow), 128'(0));
            if (i == 255) chk("sat_256_ovf", 128'(overflow), 128'(1));
        end
        chk("sat_vld_blocked", 128'(vld_out), 128'(0));
        step(4'b0000, 1, 1);
        chk("sat_vld", 128'(vld_out), 128'(1));
        chk("sat_pkt", 128'(packet_out), 128'(mk_pkt(0, 255)));
        for (int i = 0; i < 4; i++) step(4'b0000, 1, 1);
        chk("sat_drained", 128'(vld_out), 128'(0));
        chk("ovf_sticky", 128'(overflow), 128'(1));

        // Asynchronous reset while holding a packet
        step(4'b0100, 1, 0);
        step(4'b0010, 1, 0);
        chk("hold_vld", 128'(vld_out), 128'(1));
        chk("hold_pkt", 128'(packet_out), 128'(mk_pkt(2, 1)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 128'(vld_out), 128'(0));
        chk("async_rst_pkt", 128'(packet_out), 128'(0));
        chk("async_rst_ovf", 128'(overflow), 128'(0));
        step(4'b0000, 1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1, 1);
            chk($sformatf("post_rst_idle%0d", i), 128'(vld_out), 128'(0));
        end
        // Pointer back at 0: port 0 wins over port 3
        step(4'b1001, 1, 1);
        step(4'b0000, 1, 1);
        chk("post_rst_first", 128'(packet_out), 128'(mk_pkt(0, 1)));
        step(4'b0000, 1, 1);
        chk("post_rst_second", 128'(packet_out), 128'(mk_pkt(3, 1)));
        step(4'b0000, 1, 1);
        chk("post_rst_done", 128'(vld_out), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/credit_update_arbiter.md
Name: credit_update_arbiter

Overview:
- Merges the freespace-update pulses from up to NUM_IN_PORTS input ports of one leaf interface into a single stream of credit-return packets toward the BFT.
- Each port's pulses are counted in a per-port pending counter.
- A round-robin arbiter grants one port at a time and emits one packet carrying that port's coalesced credit count.
- Sits between the input ports' freespace_update outputs and the leaf-interface output packet mux.

Parameters:
- NUM_IN_PORTS, 4, number of input ports arbitrated (1..8)
- PACKET_BITS, 97, BFT packet width
- NUM_LEAF_BITS, 6, leaf id field width
- NUM_PORT_BITS, 4, port id field width
- PAYLOAD_BITS, 64, payload field width
- CNT_BITS, 8, pending-counter width per port (CNT_BITS <= PAYLOAD_BITS)
- PORT_BASE, 2, port number assigned to input port 0; port i uses PORT_BASE+i

Ports:
- clk, input, 1, single clock
- rst_n, input, 1, asynchronous active-low reset
- enable, input, 1, 1 = grants allowed; counting continues regardless
- freespace_update, input, NUM_IN_PORTS, bit i = one-cycle credit pulse from input port i
- src_leaf, input, NUM_LEAF_BITS, this leaf's id, quasi-static
- packet_out, output, PACKET_BITS, credit packet to BFT output mux
- vld_out, output, 1, packet_out valid
- ack_in, input, 1, downstream accepts packet_out this cycle
- overflow, output, 1, sticky: a pending counter saturated and dropped a pulse

Behaviour:
- Reset (rst_n=0, asynchronous): all pending counters = 0, rr pointer = 0 (port 0 highest priority first), vld_out = 0, packet_out = 0, overflow = 0. Outputs drop immediately, not at the next edge. An in-flight packet is discarded.
- Counting: on each clk edge, pending[i] += freespace_update[i].
  - Saturates at 2^CNT_BITS-1.
  - A pulse arriving at saturation is dropped and sets overflow; overflow clears only on reset.
- Output register states:
  - IDLE: vld_out=0, packet_out=0.
  - HOLD: vld_out=1, packet_out stable until ack_in=1.
- Slot free = IDLE, or HOLD with ack_in=1.
- Grant: on a cycle with slot free, enable=1 and any pending[j]!=0:
  - Winner = first j with pending[j]!=0, searching cyclically from rr pointer.
  - Next edge: load packet for j, vld_out=1, rr pointer = (j+1) mod NUM_IN_PORTS.
  - Decision uses registered counter values; pulses arriving in the grant cycle are not included.
- Packet format, MSB to LSB:
  - 1'b1
  - src_leaf
  - (PORT_BASE+j) truncated to NUM_PORT_BITS
  - zeros
  - payload = pending[j] zero-extended to PAYLOAD_BITS
- Granted counter: at the grant edge, pending[j] <= freespace_update[j] (0 or 1). The captured count is sent, and a simultaneous pulse is kept, never lost.
- Back-to-back: HOLD with ack_in=1 and another grant available loads the next packet at the same edge; vld_out stays 1 with no bubble.
- HOLD with ack_in=1 and no grant available: go to IDLE, packet_out=0.
- Latency: a pulse at edge t makes pending nonzero after t. With an IDLE output register, vld_out=1 after edge t+1, so the packet is visible in the cycle following t+1.
- enable=0:
  - No new grant is issued.
  - A packet already in HOLD remains valid until acked.
  - Counters keep accumulating.
- ack_in while IDLE: ignored.
- NUM_IN_PORTS=1: the arbiter degenerates to a single requester, and the rr pointer stays 0.

Test Plan:
- Single credit: after reset, one pulse on port 1, ack_in tied 1 -> one packet with vld_out=1 for 1 cycle; packet_out = {1, src_leaf, 4'd3, 0, payload=1}.
- Coalescing: ack_in=0 with port 0 pending; 5 pulses on port 2 -> after port 0's packet is acked, port 2 packet payload=5 and pending[2]=0.
- Round robin: pulses on ports 0..3 in the same cycle, ack_in=1 -> packets in port order 0,1,2,3 back-to-back, vld_out continuous for 4 cycles; repeated with rr pointer=2 -> order 2,3,0,1.
- Simultaneous grant and pulse: pending[1]=3 and a pulse on port 1 in the grant cycle -> packet payload=3, then a second packet with payload=1.
- Saturation: CNT_BITS=8, enable=0, 300 pulses on port 0 -> overflow=1; after enable=1, payload=255; overflow stays 1 until rst_n=0.
- Reset mid-HOLD: vld_out=1, ack_in=0, assert rst_n=0 -> vld_out and packet_out go 0 before the next edge; after release, no stale packet and counters read 0.
